operand_fetch: RTL and testbench

- Issue-side sequencer that drives the 4x8 register file's two read ports and its write port.
- Accepts decoded register requests (src1, src2, dst) over a valid/ready handshake and reads both operands. It presents them to the execute stage over a second valid/ready handshake.
- Tracks in-flight destinations in a 4-bit scoreboard and stalls on RAW/WAW hazards. It also funnels execute writebacks into the register file write port.

---
 rtl/operand_fetch.sv | 128 ++++++++++++
 tb/tb_operand_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: accepts decoded register requests, reads both
// operands from the register file, and hands them to execute. A per-register
// scoreboard of in-flight destinations stalls RAW/WAW hazards. Execute
// writebacks are funnelled straight into the register file write port.
module operand_fetch #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_src1,
  input  logic [AW-1:0] req_src2,
  input  logic [AW-1:0] req_dst,
  input  logic          req_wen,
  output logic [AW-1:0] rf_reg1,
  output logic [AW-1:0] rf_reg2,
  output logic [AW-1:0] rf_reg_w,
  output logic          rf_do_write,
  output logic [DW-1:0] rf_write_data,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic          opnd_valid,
  input  logic          opnd_ready,
  output logic [DW-1:0] opnd_a,
  output logic [DW-1:0] opnd_b,
  output logic [AW-1:0] opnd_dst,
  output logic          opnd_wen,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data
);

  localparam int NR = 1 << AW;

  // state | meaning
  // IDLE  | waiting for a hazard-free request
  // READ  | register file read in flight (data lands on the negedge)
  // HOLD  | operands presented to execute, waiting for opnd_ready
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t        state, state_nxt;
  logic [NR-1:0] scoreboard;
  logic [NR-1:0] wb_clr;
  logic [NR-1:0] busy_vec;
  logic          wb_fire;
  logic          req_fire;
  logic          hazard;
  logic          fwd_a, fwd_b;

  // Writeback decode, hazard check and handshake strobes.
  always_comb begin
    wb_ready    = reset;
    wb_fire     = wb_valid & reset;
    rf_do_write = wb_fire;
    wb_clr      = '0;
    if (wb_fire) wb_clr[wb_dst] = 1'b1;
    // A writeback landing this cycle releases its register immediately.
    busy_vec    = scoreboard & ~wb_clr;
    hazard      = busy_vec[req_src1] | busy_vec[req_src2] | (req_wen & busy_vec[req_dst]);
    req_ready   = (state == IDLE) & ~hazard & reset;
    req_fire    = req_valid & req_ready;
    fwd_a       = wb_fire & (wb_dst == rf_reg1);
    fwd_b       = wb_fire & (wb_dst == rf_reg2);
  end

  assign rf_reg_w      = wb_dst;
  assign rf_write_data = wb_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (opnd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scoreboard: fired writebacks clear, accepted writing requests set; set wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scoreboard <= '0;
    end else begin
      scoreboard <= (scoreboard & ~wb_clr) |
                    ((req_fire && req_wen) ? (NR'(1) << req_dst) : '0);
    end
  end

  // Read addresses, operand capture (with writeback forwarding) and handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_reg1    <= '0;
      rf_reg2    <= '0;
      opnd_valid <= 1'b0;
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_dst   <= '0;
      opnd_wen   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_fire) begin
          rf_reg1  <= req_src1;
          rf_reg2  <= req_src2;
          opnd_dst <= req_dst;
          opnd_wen <= req_wen;
        end
        READ: begin
          opnd_a     <= fwd_a ? wb_data : rf_data1;
          opnd_b     <= fwd_b ? wb_data : rf_data2;
          opnd_valid <= 1'b1;
        end
        HOLD: if (opnd_ready) opnd_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file and a
// queue of expected operand bundles checked when execute takes them.
module tb_operand_fetch;
  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_wen;
  logic [1:0] req_src1, req_src2, req_dst;
  logic [1:0] rf_reg1, rf_reg2, rf_reg_w;
  logic       rf_do_write;
  logic [7:0] rf_write_data, rf_data1, rf_data2;
  logic       opnd_valid, opnd_ready, opnd_wen;
  logic [7:0] opnd_a, opnd_b;
  logic [1:0] opnd_dst;
  logic       wb_valid, wb_ready;
  logic [1:0] wb_dst;
  logic [7:0] wb_data;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dst;
    logic       wen;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] rf_mem [4] = '{default: 8'h00};

  operand_fetch #(.DW(8), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wen(req_wen),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_reg_w(rf_reg_w),
    .rf_do_write(rf_do_write), .rf_write_data(rf_write_data),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_dst(opnd_dst), .opnd_wen(opnd_wen),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Register file: write on posedge, read data updates on negedge.
  always @(posedge clk) if (rf_do_write) rf_mem[rf_reg_w] <= rf_write_data;
  always @(negedge clk) begin
    rf_data1 = rf_mem[rf_reg1];
    rf_data2 = rf_mem[rf_reg2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop and compare when execute takes a bundle.
  always @(negedge clk) begin
    if (reset === 1'b1 && opnd_valid === 1'b1 && opnd_ready === 1'b1) begin
      check("opnd_q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("opnd_a", opnd_a, e.a);
        check("opnd_b", opnd_b, e.b);
        check("opnd_dst", opnd_dst, e.dst);
        check("opnd_wen", opnd_wen, e.wen);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [1:0] d, input logic [7:0] v);
    wb_valid = 1'b1; wb_dst = d; wb_data = v;
    #1;
    check("wb_do_write", rf_do_write, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("wb_do_write_off", rf_do_write, 0);
  endtask

  // Present a request, wait (bounded) for req_ready, push expectation, take the accept edge.
  task automatic accept(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
                        input logic w, input logic [7:0] ea, input logic [7:0] eb);
    int n = 0;
    req_valid = 1'b1; req_src1 = s1; req_src2 = s2; req_dst = d; req_wen = w;
    #1;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", req_ready, 1);
    exp_q.push_back('{a: ea, b: eb, dst: d, wen: w});
    tick();
    req_valid = 1'b0;
    check("read_not_valid", opnd_valid, 0);
  endtask

  task automatic consume();
    opnd_ready = 1'b1;
    tick();
    opnd_ready = 1'b0;
    check("consumed", opnd_valid, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_src1 = '0; req_src2 = '0; req_dst = '0;
    req_wen = 1'b0; opnd_ready = 1'b0; wb_valid = 1'b1; wb_dst = 2'd1; wb_data = 8'hFF;
    tick(); tick();
    req_valid = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_do_write", rf_do_write, 0);
    check("rst_opnd_valid", opnd_valid, 0);
    check("rst_rf_reg1", rf_reg1, 0);
    check("rst_opnd_a", opnd_a, 0);
    check("rst_sb", dut.scoreboard, 4'b0000);
    tick();
    reset = 1'b1; req_valid = 1'b0; wb_valid = 1'b0;
    #1;
    check("wb_ready_up", wb_ready, 1);
    check("req_ready_up", req_ready, 1);

    // Basic read with latency check.
    wb(2'd1, 8'h3C);
    wb(2'd2, 8'hA5);
    accept(2'd1, 2'd2, 2'd3, 1'b1, 8'h3C, 8'hA5);
    check("rf_reg1", rf_reg1, 1);
    check("rf_reg2", rf_reg2, 2);
    check("sb_after_accept", dut.scoreboard, 4'b1000);
    check("busy_in_read", req_ready, 0);
    tick();
    check("opnd_valid_up", opnd_valid, 1);
    consume();

    // RAW stall on r3, released by a same-cycle writeback; set wins over clear.
    req_valid = 1'b1; req_src1 = 2'd3; req_src2 = 2'd0; req_dst = 2'd3; req_wen = 1'b1;
    #1;
    check("raw_stall", req_ready, 0);
    tick();
    check("raw_stall2", req_ready, 0);
    wb_valid = 1'b1; wb_dst = 2'd3; wb_data = 8'h77;
    #1;
    check("raw_release", req_ready, 1);
    exp_q.push_back('{a: 8'h77, b: 8'h00, dst: 2'd3, wen: 1'b1});
    tick();
    req_valid = 1'b0; wb_valid = 1'b0;
    check("sb_set_wins", dut.scoreboard, 4'b1000);
    tick();
    consume();

    // Forwarding to both operands during READ.
    accept(2'd2, 2'd2, 2'd0, 1'b0, 8'h11, 8'h11);
    wb_valid = 1'b1; wb_dst = 2'd2; wb_data = 8'h11;
    tick();
    wb_valid = 1'b0;
    check("fwd_valid", opnd_valid, 1);

    // Stall in HOLD for 5 cycles with an unrelated writeback to r0.
    for (int i = 0; i < 5; i++) begin
      check("hold_a", opnd_a, 8'h11);
      check("hold_b", opnd_b, 8'h11);
      check("hold_req_ready", req_ready, 0);
      if (i == 1) wb(2'd0, 8'h5A);
      else tick();
    end
    check("hold_still_valid", opnd_valid, 1);
    consume();

    // WAW: make r2 pending, then stall a dst=2 request until r2 writes back.
    accept(2'd0, 2'd1, 2'd2, 1'b1, 8'h5A, 8'h3C);
    tick();
    consume();
    check("sb_r2_r3", dut.scoreboard, 4'b1100);
    req_valid = 1'b1; req_src1 = 2'd0; req_src2 = 2'd0; req_dst = 2'd2; req_wen = 1'b1;
    #1;
    check("waw_stall", req_ready, 0);
    tick();
    check("waw_stall2", req_ready, 0);
    wb_valid = 1'b1; wb_dst = 2'd2; wb_data = 8'h99;
    #1;
    check("waw_release", req_ready, 1);
    exp_q.push_back('{a: 8'h5A, b: 8'h5A, dst: 2'd2, wen: 1'b1});
    tick();
    req_valid = 1'b0; wb_valid = 1'b0;
    check("sb_waw", dut.scoreboard, 4'b1100);
    tick();
    check("waw_valid", opnd_valid, 1);
    consume();

    // Reset while holding a valid bundle drops it.
    accept(2'd1, 2'd0, 2'd0, 1'b0, 8'h3C, 8'h5A);
    tick();
    check("pre_rst_valid", opnd_valid, 1);
    reset = 1'b0;
    tick();
    void'(exp_q.pop_back());
    check("mid_rst_valid", opnd_valid, 0);
    check("mid_rst_sb", dut.scoreboard, 4'b0000);
    check("mid_rst_opnd_a", opnd_a, 0);
    check("mid_rst_rf_reg1", rf_reg1, 0);
    req_valid = 1'b1; req_src1 = '0; req_src2 = '0; req_wen = 1'b0;
    wb_valid = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_do_write", rf_do_write, 0);
    tick();
    check("mid_rst_req_ready2", req_ready, 0);
    reset = 1'b1; req_valid = 1'b0; wb_valid = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    check("q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
